dot8_mac: RTL and testbench
===========================

# dot8_mac

Streaming 8-bit dot-product / multiply-accumulate engine that sits downstream of `wallace_mul`, the 8×8 combinational multiplier. It registers each operand pair, registers the 16-bit product, and accumulates products into a wide accumulator until a `last`-tagged pair arrives. It then presents the vector sum on a valid/ready output. The block adds the pipelining, flow control and accumulation that the purely combinational multiplier lacks.

## Interface
- `ACC_W`, 24: accumulator and sum width; legal range ≥ 16.
- `LEN_W`, 16: width of the term counter.
- `clk`  in  1  sole clock; all state updates on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  operand pair valid.
- `in_ready`  out  1  block can accept a pair this cycle.
- `in_a`  in  8  unsigned multiplicand.
- `in_b`  in  8  unsigned multiplier.
- `in_last`  in  1  pair is the final term of the current vector.
- `out_valid`  out  1  `out_sum`, `out_len` and `out_ovf` are valid.
- `out_ready`  in  1  consumer accepts the result.
- `out_sum`  out  ACC_W  sum of products, modulo 2^ACC_W.
- `out_len`  out  LEN_W  number of terms in the vector, modulo 2^LEN_W.
- `out_ovf`  out  1  sticky flag; set if any accumulate in the vector carried out of ACC_W.

## Operation
- **Pipeline**
  - S1: operand registers `a1`, `b1`, `last1`, `v1`.
  - S2: product register `p2[15:0] = a1*b1` via `wallace_mul`, plus `last2` and `v2`.
  - ACC: accumulator `acc`, length counter `len`, overflow bit `ovf`, and the output holding register.
- **Global stall**: `en = !out_valid || out_ready`.
  - `in_ready = en && !rst`.
  - S1, S2 and ACC update only when `en` is high; otherwise all hold.
  - Accept occurs on `in_valid && in_ready`. When `en` is high and no pair is accepted, a bubble (`v1 = 0`) enters S1.
- **Accumulator state machine** (`acc_st`):
  - `IDLE`: the next valid S2 term starts a new vector.
  - `RUN`: a vector is in progress.
- **On each enabled cycle with `v2 = 1`**:
  - Term value: `base = (acc_st == IDLE) ? 0 : acc`.
  - `sum = base + zero-extend(p2)`, computed in ACC_W+1 bits.
  - `nlen = (IDLE ? 0 : len) + 1`.
  - `novf = (IDLE ? 0 : ovf) | sum[ACC_W]`.
  - If `last2 = 0`: `acc <= sum[ACC_W-1:0]`, `len <= nlen`, `ovf <= novf`, `acc_st <= RUN`.
  - If `last2 = 1`: load `out_sum`, `out_len`, `out_ovf` from these values; set `out_valid <= 1`; `acc_st <= IDLE`.
- **Output handshake**: `out_valid` clears on `out_valid && out_ready` unless a new last term loads in the same cycle, in which case the output register reloads and `out_valid` stays 1.
- **Bubbles**: `v2 = 0` leaves `acc`, `len`, `ovf` and `acc_st` unchanged.
- **Arithmetic**:
  - All operands are unsigned.
  - The sum wraps modulo 2^ACC_W; wrap is reported only via `out_ovf`.
  - `len` wraps silently.
- **Output stability**: while `out_valid && !out_ready`, all output payload bits hold stable.

## Timing
- **Reset values**: `out_valid = 0`, `out_sum = 0`, `out_len = 0`, `out_ovf = 0`, `in_ready = 0` while `rst` is high, `v1 = v2 = 0`, `acc = 0`, `len = 0`, `ovf = 0`, `acc_st = IDLE`.
- **Reset mid-operation**: reset mid-vector or mid-stall discards all in-flight terms and any pending output. There is no output for the aborted vector.
- **Latency**: for a pair accepted at edge E, its product reaches S2 at E+1 and its ACC update happens at E+2. For a last term, `out_valid` is high in the cycle following E+2.
- **Throughput**: one pair per cycle while `out_ready` stays high or no result is pending.
- **Backpressure**: with `out_valid = 1` and `out_ready = 0`, `in_ready` is 0 and the pipeline freezes. There is no bubble insertion and no loss.
- **Same-cycle release**: `out_ready` rising releases the stall in the same cycle (`in_ready` is combinational from `out_ready`).
- **Simultaneous events**: drain plus a new last in the same cycle gives back-to-back results on consecutive cycles.

## Structure
- Shared package `mac_pkg` holds:
  - `acc_st_t` enum (`IDLE`, `RUN`).
  - Default constants `ACC_W_DEF = 24` and `LEN_W_DEF = 16`.
  - Operand/product widths `OP_W = 8` and `PROD_W = 16`.
- Single sub-module: one `wallace_mul` instance, fed by `a1`/`b1` and driving the S2 register input.
- No other hierarchy; S1, S2, ACC and the output register live in the top module.

## Test plan
- **Single term**: pair `a=255`, `b=255`, `last=1` into an idle block.
  - `out_valid` is high 2 cycles after the accept edge.
  - `out_sum = 65025`, `out_len = 1`, `out_ovf = 0`.
- **Four-term vector**: `a = {1,2,3,4}`, `b = {5,6,7,8}` on back-to-back cycles, `last` on the 4th.
  - `out_sum = 70`, `out_len = 4`.
  - Insert random `in_valid` gaps: same result.
- **Overflow**: with ACC_W=24, send 258 pairs of 255×255.
  - Result: 16776450, `ovf = 0`.
  - Then 259 pairs: `out_sum = 64259`, `out_len = 259`, `out_ovf = 1`.
  - The next vector (1×1) returns `ovf = 0`.
- **Backpressure**: two single-term vectors (3×4, then 5×6) with `out_ready` held low.
  - First result 12 stays stable.
  - `in_ready` is 0 while it is pending.
  - Raise `out_ready` for 1 cycle: 12 is accepted and 30 appears on the next cycle. No duplication or loss.
- **Reset mid-vector**: send 3 non-last terms (10×10), pulse `rst` for 1 cycle, then send 2×3 with `last`.
  - `out_sum = 6`, `out_len = 1`.
  - All outputs are 0 and `out_valid` is 0 during reset.
- **Drain/load collision**: stream 1×1 `last`, 2×2 `last`, 3×3 `last` contiguously with `out_ready = 1`.
  - Results 1, 4, 9 appear on 3 consecutive cycles.

Source files
------------

// File: rtl/mac_pkg.sv
// Shared types and constants for the dot8_mac streaming dot-product engine.
package mac_pkg;

   // Accumulator state: IDLE means the next valid term starts a new vector.
   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } acc_st_t;

   localparam int ACC_W_DEF = 24;
   localparam int LEN_W_DEF = 16;
   localparam int OP_W      = 8;
   localparam int PROD_W    = 16;

endpackage

// File: rtl/wallace_mul.sv
// Combinational 8x8 unsigned multiplier. Partial products are folded through
// a chain of 3:2 carry-save compressors; one carry-propagate add at the end.
module wallace_mul
   import mac_pkg::*;
(
   input  logic [OP_W-1:0]   a_i,
   input  logic [OP_W-1:0]   b_i,
   output logic [PROD_W-1:0] p_o
);

   logic [PROD_W-1:0] s;
   logic [PROD_W-1:0] c;
   logic [PROD_W-1:0] s_n;
   logic [PROD_W-1:0] pp;

   // Carry-save reduction of the shifted partial products, then final add.
   always_comb begin
      // NOTE: every variable gets a default before any conditional use so no latch is inferred.
      s   = '0;
      c   = '0;
      s_n = '0;
      pp  = '0;
      for (int i = 0; i < OP_W; i++) begin
         pp  = PROD_W'(a_i & {OP_W{b_i[i]}}) << i;
         s_n = s ^ c ^ pp;
         c   = ((s & c) | (s & pp) | (c & pp)) << 1;
         s   = s_n;
      end
      p_o = s + c;
   end

endmodule

// File: rtl/dot8_mac.sv
// Streaming 8-bit multiply-accumulate: operand stage, product stage and an
// accumulator that emits one sum per last-tagged vector on a valid/ready port.
module dot8_mac
   import mac_pkg::*;
#(
   parameter int ACC_W = ACC_W_DEF,
   parameter int LEN_W = LEN_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [OP_W-1:0]  in_a,
   input  logic [OP_W-1:0]  in_b,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] out_sum,
   output logic [LEN_W-1:0] out_len,
   output logic             out_ovf
);

   // S1 operand stage
   logic [OP_W-1:0]   a1_q, b1_q;
   logic              last1_q, v1_q;
   // S2 product stage
   logic [PROD_W-1:0] p2_q;
   logic              last2_q, v2_q;
   // ACC stage
   logic [ACC_W-1:0]  acc_q;
   logic [LEN_W-1:0]  len_q;
   logic              ovf_q;
   acc_st_t           acc_st_q;
   // Output holding register
   logic [ACC_W-1:0]  out_sum_q;
   logic [LEN_W-1:0]  out_len_q;
   logic              out_ovf_q;
   logic              out_valid_q;

   logic [PROD_W-1:0] prod;
   logic              en;
   logic              accept;
   logic [ACC_W-1:0]  acc_base;
   logic [LEN_W-1:0]  len_base;
   logic [ACC_W:0]    sum_d;
   logic [LEN_W-1:0]  nlen_d;
   logic              novf_d;

   wallace_mul u_mul (
      .a_i (a1_q),
      .b_i (b1_q),
      .p_o (prod)
   );

   // The whole pipeline advances only when no result is blocked downstream.
   assign en        = !out_valid_q || out_ready;
   assign in_ready  = en && !rst;
   assign accept    = in_valid && in_ready;

   assign out_valid = out_valid_q;
   assign out_sum   = out_sum_q;
   assign out_len   = out_len_q;
   assign out_ovf   = out_ovf_q;

   // Next accumulator values; an IDLE state starts the vector from zero.
   always_comb begin
      acc_base = (acc_st_q == IDLE) ? '0 : acc_q;
      len_base = (acc_st_q == IDLE) ? '0 : len_q;
      sum_d    = {1'b0, acc_base} + {{(ACC_W + 1 - PROD_W){1'b0}}, p2_q};
      nlen_d   = len_base + LEN_W'(1);
      novf_d   = ((acc_st_q == IDLE) ? 1'b0 : ovf_q) | sum_d[ACC_W];
   end

   // Pipeline stages, accumulator state machine and output register.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
      if (rst) begin
         a1_q        <= '0;
         b1_q        <= '0;
         last1_q     <= 1'b0;
         v1_q        <= 1'b0;
         p2_q        <= '0;
         last2_q     <= 1'b0;
         v2_q        <= 1'b0;
         acc_q       <= '0;
         len_q       <= '0;
         ovf_q       <= 1'b0;
         acc_st_q    <= IDLE;
         out_sum_q   <= '0;
         out_len_q   <= '0;
         out_ovf_q   <= 1'b0;
         out_valid_q <= 1'b0;
      end else if (en) begin
         v1_q    <= accept;
         a1_q    <= in_a;
         b1_q    <= in_b;
         last1_q <= in_last;

         v2_q    <= v1_q;
         p2_q    <= prod;
         last2_q <= last1_q;

         // en with a pending result implies the consumer is taking it now.
         if (out_valid_q) begin
            out_valid_q <= 1'b0;
         end

         if (v2_q) begin
            if (last2_q) begin
               out_sum_q   <= sum_d[ACC_W-1:0];
               out_len_q   <= nlen_d;
               out_ovf_q   <= novf_d;
               out_valid_q <= 1'b1;
               acc_st_q    <= IDLE;
            end else begin
               acc_q    <= sum_d[ACC_W-1:0];
               len_q    <= nlen_d;
               ovf_q    <= novf_d;
               acc_st_q <= RUN;
            end
         end
      end
   end

endmodule

// File: tb/tb_dot8_mac.sv
// Scoreboard bench for dot8_mac: the driver records the mathematically exact
// dot product of each vector; a monitor compares every delivered result.
module tb_dot8_mac;

   localparam int ACC_W = 24;
   localparam int LEN_W = 16;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [7:0]       in_a = '0;
   logic [7:0]       in_b = '0;
   logic             in_last = 1'b0;
   logic             out_valid;
   logic             out_ready = 1'b1;
   logic [ACC_W-1:0] out_sum;
   logic [LEN_W-1:0] out_len;
   logic             out_ovf;

   dot8_mac #(.ACC_W(ACC_W), .LEN_W(LEN_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum),
      .out_len   (out_len),
      .out_ovf   (out_ovf)
   );

   always #5 clk = ~clk;

   typedef struct {
      longint sum;
      longint len;
      bit     ovf;
   } exp_t;

   exp_t   sb[$];
   int     pop_cyc[$];
   longint m_total = 0;
   longint m_len   = 0;
   int     checks  = 0;
   int     errors  = 0;
   int     cyc     = 0;
   int     rdy_mode = 1;   // 0: hold low, 1: hold high, 2: random

   always @(posedge clk) cyc++;

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Consumer: out_ready changes 2ns after each rising edge.
   initial begin
      forever begin
         @(posedge clk);
         #2;
         case (rdy_mode)
            0:       out_ready = 1'b0;
            1:       out_ready = 1'b1;
            default: out_ready = 1'($urandom_range(0, 1));
         endcase
      end
   end

   // Monitor: compares delivered results and checks stall behaviour.
   initial begin
      bit               hold;
      logic [ACC_W-1:0] h_sum;
      logic [LEN_W-1:0] h_len;
      logic             h_ovf;
      exp_t             e;
      hold = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            hold = 1'b0;
         end else begin
            if (hold) begin
               check("stall_valid", out_valid, 1);
               check("stall_sum", out_sum, h_sum);
               check("stall_len", out_len, h_len);
               check("stall_ovf", out_ovf, h_ovf);
            end
            if (out_valid && !out_ready) begin
               check("stall_in_ready", in_ready, 0);
               hold  = 1'b1;
               h_sum = out_sum;
               h_len = out_len;
               h_ovf = out_ovf;
            end else begin
               hold = 1'b0;
            end
            if (!out_valid) check("idle_in_ready", in_ready, 1);
            if (out_valid && out_ready) begin
               if (sb.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_result: got sum %0d len %0d, expected no result", out_sum, out_len);
               end else begin
                  e = sb.pop_front();
                  check("result_sum", out_sum, e.sum);
                  check("result_len", out_len, e.len);
                  check("result_ovf", out_ovf, e.ovf);
                  pop_cyc.push_back(cyc);
               end
            end
         end
      end
   end

   // Offer one pair until accepted; fold it into the exact reference sum.
   task automatic send(input logic [7:0] a, input logic [7:0] b, input bit last);
      int   n;
      bit   took;
      exp_t e;
      n = 0;
      took = 1'b0;
      in_valid = 1'b1;
      in_a     = a;
      in_b     = b;
      in_last  = last;
      do begin
         @(negedge clk);
         took = in_ready;
         @(posedge clk);
         #1;
         n++;
      end while (!took && n < 200);
      in_valid = 1'b0;
      in_last  = 1'b0;
      if (!took) begin
         checks++;
         errors++;
         $display("FAIL send_timeout: got no accept in %0d cycles, expected accept", n);
      end else begin
         m_total += longint'(a) * longint'(b);
         m_len++;
         if (last) begin
            e.sum = m_total % (longint'(1) << ACC_W);
            e.len = m_len % (longint'(1) << LEN_W);
            e.ovf = (m_total >= (longint'(1) << ACC_W));
            sb.push_back(e);
            m_total = 0;
            m_len   = 0;
         end
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // One-edge reset pulse; everything in flight is discarded.
   task automatic do_reset();
      rst = 1'b1;
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      check("rst_out_valid", out_valid, 0);
      check("rst_out_sum", out_sum, 0);
      check("rst_out_len", out_len, 0);
      check("rst_out_ovf", out_ovf, 0);
      check("rst_in_ready", in_ready, 0);
      rst = 1'b0;
      sb.delete();
      m_total = 0;
      m_len   = 0;
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      rdy_mode = 1;
      while (sb.size() > 0 && n < 500) begin
         @(posedge clk);
         n++;
      end
      #1;
      if (sb.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout: got %0d results outstanding, expected 0", sb.size());
      end
      idle(2);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no completion, expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int len;
      // Reset state
      @(posedge clk);
      #1;
      do_reset();
      idle(2);

      // Single term with latency check
      rdy_mode = 1;
      send(8'd255, 8'd255, 1'b1);
      @(negedge clk);
      check("lat_e0", out_valid, 0);
      @(negedge clk);
      check("lat_e1", out_valid, 0);
      @(negedge clk);
      check("lat_e2", out_valid, 1);
      @(posedge clk);
      #1;
      wait_drain();

      // Four-term vector, back to back and then with random gaps
      for (int i = 0; i < 4; i++) send(8'(i + 1), 8'(i + 5), i == 3);
      wait_drain();
      for (int i = 0; i < 4; i++) begin
         idle($urandom_range(0, 3));
         send(8'(i + 1), 8'(i + 5), i == 3);
      end
      wait_drain();

      // Overflow boundary: 258 terms fit, 259 wrap, then a fresh vector
      for (int i = 0; i < 258; i++) send(8'd255, 8'd255, i == 257);
      for (int i = 0; i < 259; i++) send(8'd255, 8'd255, i == 258);
      send(8'd1, 8'd1, 1'b1);
      wait_drain();

      // Backpressure: result held stable, input stalled, one-cycle release
      rdy_mode = 0;
      idle(1);
      send(8'd3, 8'd4, 1'b1);
      send(8'd5, 8'd6, 1'b1);
      idle(6);
      @(negedge clk);
      check("bp_in_ready", in_ready, 0);
      check("bp_first_sum", out_sum, 12);
      @(posedge clk);
      #1;
      rdy_mode = 1;
      @(posedge clk);
      #1;
      rdy_mode = 0;
      idle(3);
      @(negedge clk);
      check("bp_second_valid", out_valid, 1);
      check("bp_second_sum", out_sum, 30);
      @(posedge clk);
      #1;
      wait_drain();

      // Reset mid-vector
      for (int i = 0; i < 3; i++) send(8'd10, 8'd10, 1'b0);
      do_reset();
      send(8'd2, 8'd3, 1'b1);
      wait_drain();

      // Drain/load collision: three results on consecutive cycles
      pop_cyc.delete();
      send(8'd1, 8'd1, 1'b1);
      send(8'd2, 8'd2, 1'b1);
      send(8'd3, 8'd3, 1'b1);
      wait_drain();
      check("coll_count", pop_cyc.size(), 3);
      if (pop_cyc.size() == 3) begin
         check("coll_gap01", pop_cyc[1] - pop_cyc[0], 1);
         check("coll_gap12", pop_cyc[2] - pop_cyc[1], 1);
      end

      // Random vectors with random gaps and random consumer stalls
      rdy_mode = 2;
      for (int v = 0; v < 40; v++) begin
         len = $urandom_range(1, 8);
         for (int i = 0; i < len; i++) begin
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
            send(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), i == len - 1);
         end
      end
      wait_drain();

      check("sb_empty", sb.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
